spi_target: RTL and testbench

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync.sv | 34 +++
 rtl/spi_target.sv | 179 +++++++++++++++++
 tb/tb_spi_target.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg -- constants shared by the dual-lane SPI master and target.
//   LANES          : data lanes per direction (2 bits move per sck period)
//   SPI_MODE       : clock mode (0: sck idles low, sample on rise, shift on fall)
//   lane_t         : one bit per lane, lane 0 carries the more significant bit
//   pairs_per_word : sck periods needed for one word of a given width
package spi_pkg;

  localparam int LANES    = 2;
  localparam int SPI_MODE = 0;

  typedef logic [0:LANES-1] lane_t;

  function automatic int pairs_per_word(input int data_w);
    return data_w / LANES;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync -- two-flop synchroniser followed by a rise/fall edge detector.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   din   : asynchronous input
//   rise  : one-cycle pulse on a synchronised 0->1 transition
//   fall  : one-cycle pulse on a synchronised 1->0 transition
module spi_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign rise = sync_reg & ~prev_reg;
  assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/spi_target.sv
// spi_target -- dual-lane SPI target (mode 0), oversampled by the system clock.
//   I_clk         : system clock, rising edge
//   I_rst         : asynchronous active-low reset
//   I_sck/I_cs_n  : serial clock and active-low chip select from the master
//   I_mosi        : master-to-target lanes, lane 0 = bit n, lane 1 = bit n-1
//   O_miso        : target-to-master lanes, 00 while deselected
//   O_rx_data     : last complete received word, O_rx_valid pulses on update
//   I_tx_data/I_tx_valid/O_tx_ready : one-word holding register for transmit
//   O_tx_underrun : pulses when a word is loaded from an empty holding register
module spi_target
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_sck,
  input  logic              I_cs_n,
  input  logic [0:1]        I_mosi,
  output logic [0:1]        O_miso,
  output logic [DATA_W-1:0] O_rx_data,
  output logic              O_rx_valid,
  input  logic [DATA_W-1:0] I_tx_data,
  input  logic              I_tx_valid,
  output logic              O_tx_ready,
  output logic              O_tx_underrun
);

  localparam int PAIRS = pairs_per_word(DATA_W);
  localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);

  // ---------------------------------------------------------------- sync
  logic  sck_rise, sck_fall;
  logic  cs_n_rise, cs_n_fall;
  lane_t mosi_sync;

  spi_sync u_sck_sync (
    .clk   (I_clk),
    .rst_n (I_rst),
    .din   (I_sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync u_cs_sync (
    .clk   (I_clk),
    .rst_n (I_rst),
    .din   (I_cs_n),
    .rise  (cs_n_rise),
    .fall  (cs_n_fall)
  );

  // Data lanes get the same two-flop delay as sck so they stay aligned
  // with the detected sck edges.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_mosi_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= I_mosi[gi];
          sync_reg <= meta_reg;
        end
      end
      assign mosi_sync[gi] = sync_reg;
    end
  endgenerate

  // ------------------------------------------------------- select state
  // The target only takes part after it has seen cs assert. Coming out of
  // reset with cs already low therefore ignores that transfer entirely.
  logic armed_reg;
  logic active;

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      armed_reg <= 1'b0;
    end else if (cs_n_fall) begin
      armed_reg <= 1'b1;
    end else if (cs_n_rise) begin
      armed_reg <= 1'b0;
    end
  end

  // An sck edge seen in the same cycle as cs deassertion belongs to the
  // end of the frame and must not shift or load anything.
  assign active = armed_reg & ~cs_n_rise;

  // ------------------------------------------------------------ receive
  logic [DATA_W-3:0]  rx_shift_reg;
  logic [CNT_W-1:0]   pair_cnt_reg;
  logic [DATA_W-1:0]  rx_data_reg;
  logic               rx_valid_reg;
  logic [DATA_W-1:0]  rx_word;
  logic               word_done;

  assign rx_word   = {rx_shift_reg, mosi_sync};
  assign word_done = sck_rise & active & (pair_cnt_reg == LAST_PAIR);

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      rx_shift_reg <= '0;
      pair_cnt_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_valid_reg <= word_done;
      if (word_done) begin
        rx_data_reg <= rx_word;
      end
      // A partial word is simply abandoned: the counter restarts and the
      // shift register contents are never published.
      if (!active) begin
        pair_cnt_reg <= '0;
      end else if (sck_rise) begin
        rx_shift_reg <= rx_word[DATA_W-3:0];
        pair_cnt_reg <= (pair_cnt_reg == LAST_PAIR) ? '0 : pair_cnt_reg + 1'b1;
      end
    end
  end

  assign O_rx_data  = rx_data_reg;
  assign O_rx_valid = rx_valid_reg;

  // ----------------------------------------------------------- transmit
  logic [DATA_W-1:0] tx_shift_reg;
  logic [DATA_W-1:0] hold_data_reg;
  logic              hold_full_reg;
  logic              underrun_reg;
  logic              tx_load;
  logic              tx_shift;
  logic              tx_accept;

  // Loads happen at frame start and at the falling edge that opens each
  // following word (counter already wrapped to 0 by the previous rise).
  assign tx_load   = cs_n_fall | (sck_fall & active & (pair_cnt_reg == '0));
  assign tx_shift  = sck_fall & active & (pair_cnt_reg != '0);
  assign tx_accept = I_tx_valid & ~hold_full_reg;

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      tx_shift_reg  <= '0;
      hold_data_reg <= '0;
      hold_full_reg <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      underrun_reg <= tx_load & ~hold_full_reg;
      if (tx_load) begin
        tx_shift_reg <= hold_full_reg ? hold_data_reg : '0;
      end else if (tx_shift) begin
        tx_shift_reg <= {tx_shift_reg[DATA_W-3:0], 2'b00};
      end
      // Accept only happens while empty, so a simultaneous load has
      // already underrun on the old state and the new word waits for the
      // next load.
      if (tx_accept) begin
        hold_data_reg <= I_tx_data;
        hold_full_reg <= 1'b1;
      end else if (tx_load) begin
        hold_full_reg <= 1'b0;
      end
    end
  end

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_miso
      assign O_miso[gi] = armed_reg & tx_shift_reg[DATA_W-1-gi];
    end
  endgenerate

  assign O_tx_ready    = ~hold_full_reg;
  assign O_tx_underrun = underrun_reg;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target -- bench for spi_target: a dual-lane mode-0 master running
// sck at clk/8, a word-level model of the holding register and receive
// stream, a per-cycle compare process and directed plus random transfers.
module tb_spi_target;
  import spi_pkg::*;

  localparam int W     = 8;
  localparam int PAIRS = W / LANES;
  localparam int HALF  = 4;  // clk cycles per sck half period

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sck = 1'b0;
  logic         cs_n = 1'b1;
  logic [0:1]   mosi = 2'b00;
  logic [0:1]   miso;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         tx_underrun;

  always #5 clk = ~clk;

  spi_target #(.DATA_W(W)) dut (
    .I_clk         (clk),
    .I_rst         (rst_n),
    .I_sck         (sck),
    .I_cs_n        (cs_n),
    .I_mosi        (mosi),
    .O_miso        (miso),
    .O_rx_data     (rx_data),
    .O_rx_valid    (rx_valid),
    .I_tx_data     (tx_data),
    .I_tx_valid    (tx_valid),
    .O_tx_ready    (tx_ready),
    .O_tx_underrun (tx_underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // word-level model
  bit           model_full = 1'b0;
  logic [W-1:0] model_hold = '0;
  logic [W-1:0] rx_q[$];
  int           exp_underrun = 0;
  int           obs_underrun = 0;
  bit           monitor_on = 1'b0;
  bit           quiet = 1'b0;
  logic [W-1:0] last_rx = '0;
  logic [W-1:0] mwords[4];
  logic [W-1:0] got_tx[4];
  logic [W-1:0] exp_tx[4];
  logic         ready_at_load = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // a load takes the held word if present, otherwise zeros plus an underrun
  task automatic model_load(output logic [W-1:0] v);
    if (model_full) begin
      v = model_hold;
      model_full = 1'b0;
    end else begin
      v = '0;
      exp_underrun++;
    end
  endtask

  // per-cycle compare process
  always @(negedge clk) begin
    if (monitor_on) begin
      if (tx_underrun) obs_underrun++;
      if (rx_valid) begin
        if (rx_q.size() == 0) begin
          chk("rx_valid_unexpected", {31'b0, rx_valid}, 32'd0);
        end else begin
          chk("rx_data", {24'b0, rx_data}, {24'b0, rx_q.pop_front()});
        end
        last_rx = rx_data;
      end
      if (quiet) begin
        chk("idle_miso", {30'b0, miso}, 32'd0);
        chk("idle_tx_ready", {31'b0, tx_ready}, {31'b0, !model_full});
        chk("idle_underrun", {31'b0, tx_underrun}, 32'd0);
        chk("idle_rx_valid", {31'b0, rx_valid}, 32'd0);
      end
    end
  end

  task automatic push_tx(input logic [W-1:0] d);
    quiet = 1'b0;
    tx_data = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    if (!model_full) begin
      model_hold = d;
      model_full = 1'b1;
    end
    tick(1);
    quiet = 1'b1;
  endtask

  // One cs-framed transfer: nfull complete words from mwords[], then an
  // optional partial word of 'part' pairs. With inject set, I_tx_valid is
  // raised in the cycle the target sees cs fall.
  task automatic xfer(input int nfull, input int part, input bit inject, input logic [W-1:0] inj);
    int nstart;
    int pairs;
    bit was_full;
    logic [W-1:0] cap;
    nstart = nfull + ((part > 0) ? 1 : 0);
    quiet = 1'b0;
    cs_n = 1'b0;
    was_full = model_full;
    model_load(exp_tx[0]);
    for (int w = 0; w < nstart; w++) begin
      pairs = (w < nfull) ? PAIRS : part;
      cap = '0;
      if (w > 0) model_load(exp_tx[w]);
      for (int p = 0; p < pairs; p++) begin
        if (!(w == 0 && p == 0)) sck = 1'b0;
        mosi = {mwords[w][W-1-2*p], mwords[w][W-2-2*p]};
        if (w == 0 && p == 0) begin
          if (inject) begin
            tick(2);
            tx_data = inj;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
            if (!was_full) begin
              model_hold = inj;
              model_full = 1'b1;
            end
            tick(HALF - 3);
          end else begin
            tick(HALF);
          end
          ready_at_load = tx_ready;
          chk("ready_after_load", {31'b0, tx_ready}, {31'b0, !model_full});
        end else begin
          tick(HALF);
        end
        sck = 1'b1;
        cap = {cap[W-3:0], miso[0], miso[1]};
        if (w < nfull && p == pairs - 1) rx_q.push_back(mwords[w]);
        tick(HALF);
      end
      got_tx[w] = cap;
    end
    sck = 1'b0;
    cs_n = 1'b1;
    mosi = 2'b00;
    tick(3 * HALF);
    chk("underrun_count", obs_underrun, exp_underrun);
    chk("rx_drained", rx_q.size(), 32'd0);
    for (int w = 0; w < nfull; w++) chk("miso_word", {24'b0, got_tx[w]}, {24'b0, exp_tx[w]});
    $display("[TB] xfer full=%0d partial_pairs=%0d inject=%0b mosi0=%h miso0=%h",
             nfull, part, inject, mwords[0], got_tx[0]);
    quiet = 1'b1;
  endtask

  initial begin
    int u0;
    int nfull;
    int part;
    bit inj;

    // reset state
    tick(3);
    chk("rst_miso", {30'b0, miso}, 32'd0);
    chk("rst_rx_data", {24'b0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    chk("rst_underrun", {31'b0, tx_underrun}, 32'd0);
    rst_n = 1'b1;
    tick(3);
    monitor_on = 1'b1;
    quiet = 1'b1;
    tick(4);

    // single word 0xA5 received
    mwords[0] = 8'hA5;
    xfer(1, 0, 1'b0, '0);
    chk("rx_A5", {24'b0, last_rx}, 32'hA5);

    // preloaded 0x3C transmitted, ready rises at the frame-start load
    push_tx(8'h3C);
    chk("ready_low_after_preload", {31'b0, tx_ready}, 32'd0);
    mwords[0] = 8'h96;
    xfer(1, 0, 1'b0, '0);
    chk("tx_3C", {24'b0, got_tx[0]}, 32'h3C);
    chk("ready_rise_at_load", {31'b0, ready_at_load}, 32'd1);

    // back-to-back words with one word preloaded
    push_tx(8'h81);
    u0 = obs_underrun;
    mwords[0] = 8'h12;
    mwords[1] = 8'h34;
    xfer(2, 0, 1'b0, '0);
    chk("tx_81", {24'b0, got_tx[0]}, 32'h81);
    chk("tx_00", {24'b0, got_tx[1]}, 32'h00);
    chk("underrun_once", obs_underrun - u0, 32'd1);

    // abort after 2 pairs, then a clean word
    mwords[0] = 8'hC3;
    xfer(0, 2, 1'b0, '0);
    mwords[0] = 8'h5A;
    xfer(1, 0, 1'b0, '0);
    chk("rx_5A", {24'b0, last_rx}, 32'h5A);

    // reset mid-word, the interrupted frame must be ignored afterwards
    push_tx(8'h77);
    quiet = 1'b0;
    cs_n = 1'b0;
    mosi = 2'b11;
    tick(HALF);
    for (int p = 0; p < 2; p++) begin
      sck = 1'b1; tick(HALF);
      sck = 1'b0; tick(HALF);
    end
    sck = 1'b1;
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_miso", {30'b0, miso}, 32'd0);
    chk("midrst_rx_data", {24'b0, rx_data}, 32'd0);
    chk("midrst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("midrst_tx_ready", {31'b0, tx_ready}, 32'd1);
    chk("midrst_underrun", {31'b0, tx_underrun}, 32'd0);
    model_full = 1'b0;
    rx_q.delete();
    tick(3);
    rst_n = 1'b1;
    for (int p = 0; p < PAIRS; p++) begin
      sck = 1'b0; tick(HALF);
      sck = 1'b1; tick(HALF);
    end
    sck = 1'b0;
    cs_n = 1'b1;
    tick(3 * HALF);
    chk("post_rst_underrun", obs_underrun, exp_underrun);
    quiet = 1'b1;
    tick(2);
    mwords[0] = 8'hFF;
    xfer(1, 0, 1'b0, '0);
    chk("rx_FF", {24'b0, last_rx}, 32'hFF);

    // tx_valid in the same cycle as the frame-start load while empty
    u0 = obs_underrun;
    mwords[0] = 8'h3B;
    xfer(1, 0, 1'b1, 8'h11);
    chk("inject_underrun", obs_underrun - u0, 32'd1);
    chk("inject_first_word", {24'b0, got_tx[0]}, 32'h00);
    mwords[0] = 8'h6E;
    xfer(1, 0, 1'b0, '0);
    chk("tx_11", {24'b0, got_tx[0]}, 32'h11);

    // random transfers
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) push_tx(W'($urandom));
      nfull = int'($urandom_range(0, 3));
      part = (nfull == 0 || $urandom_range(0, 3) == 0) ? int'($urandom_range(1, PAIRS - 1)) : 0;
      inj = ($urandom_range(0, 4) == 0);
      for (int w = 0; w < 4; w++) mwords[w] = W'($urandom);
      xfer(nfull, part, inj, W'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, time limit reached");
    $fatal(1, "time limit");
  end

endmodule
